// File: rtl/decode_writeback.sv
// decode_writeback: SEQ register file with decode-side read ports,
// write-back retirement and the sticky processor status register.
// Optional retired-instruction counter enabled with `define DWB_RETIRE_CNT_EN.
module decode_writeback #(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = DATA_W'(8192)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic              instr_valid,
    input  logic              adr_err,
    input  logic [DATA_W-1:0] ValE,
    input  logic [DATA_W-1:0] ValM,
    output logic [DATA_W-1:0] ValA,
    output logic [DATA_W-1:0] ValB,
    output logic [1:0]        stat,
    output logic              halted
`ifdef DWB_RETIRE_CNT_EN
    ,
    output logic [63:0]       retired
`endif
);

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] REG_RSP = 4'h4;
    localparam int         NREGS   = 15;

    typedef enum logic [1:0] {
        S_AOK = 2'd0,
        S_HLT = 2'd1,
        S_ADR = 2'd2,
        S_INS = 2'd3
    } stat_e;

    logic [DATA_W-1:0] r_regs [NREGS];
    stat_e             r_stat;
    stat_e             w_stat_nxt;
    logic [3:0]        w_srcA;
    logic [3:0]        w_srcB;
    logic [3:0]        w_dstE;
    logic [3:0]        w_dstM;
    logic              w_retire;

    // Source register selection for the two read ports.
    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        case (icode)
            4'h2, 4'h6:       w_srcA = rA;
            4'h4:             w_srcA = rA;
            4'hA:             w_srcA = rA;
            4'h9, 4'hB:       w_srcA = REG_RSP;
            default:          w_srcA = RNONE;
        endcase
        case (icode)
            4'h4, 4'h5, 4'h6:       w_srcB = rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_srcB = REG_RSP;
            default:                w_srcB = RNONE;
        endcase
    end

    // Destination selection; cmovXX only targets rB when the condition holds.
    always_comb begin
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (icode)
            4'h2:                   w_dstE = cnd ? rB : RNONE;
            4'h3, 4'h6:             w_dstE = rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_dstE = REG_RSP;
            default:                w_dstE = RNONE;
        endcase
        case (icode)
            4'h5, 4'hB: w_dstM = rA;
            default:    w_dstM = RNONE;
        endcase
    end

    // Combinational reads of pre-edge contents; RNONE falls through to zero.
    always_comb begin
        ValA = '0;
        ValB = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (w_srcA == 4'(i)) ValA = r_regs[i];
            if (w_srcB == 4'(i)) ValB = r_regs[i];
        end
    end

    // An instruction retires only from AOK and only if it neither faults nor halts.
    assign w_retire = (r_stat == S_AOK) && instr_valid && !adr_err && (icode != 4'h0);

    // Status next-state: sticky once non-AOK, fault priority INS > ADR > HLT.
    always_comb begin
        w_stat_nxt = r_stat;
        if (r_stat == S_AOK) begin
            if (!instr_valid)        w_stat_nxt = S_INS;
            else if (adr_err)        w_stat_nxt = S_ADR;
            else if (icode == 4'h0)  w_stat_nxt = S_HLT;
            else                     w_stat_nxt = S_AOK;
        end
    end

    // Status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stat <= S_AOK;
        else        r_stat <= w_stat_nxt;
    end

    // Register file write-back; the M port wins when both target one register
    // (popq %rsp leaves the popped value in %rsp).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= (i == int'(REG_RSP)) ? RSP_INIT : '0;
        end else if (w_retire) begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_dstM == 4'(i))      r_regs[i] <= ValM;
                else if (w_dstE == 4'(i)) r_regs[i] <= ValE;
            end
        end
    end

    assign stat   = r_stat;
    assign halted = (r_stat != S_AOK);

`ifdef DWB_RETIRE_CNT_EN
    logic [63:0] r_retired;

    // Count retired instructions; wraps naturally at 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + 64'd1;
    end

    assign retired = r_retired;
`endif

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: vector table through a stat scoreboard plus
// hand sequences for async reset and the optional retire counter.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode, rA, rB;
    logic        cnd, instr_valid, adr_err;
    logic [63:0] ValE, ValM, ValA, ValB;
    logic [1:0]  stat;
    logic        halted;
`ifdef DWB_RETIRE_CNT_EN
    logic [63:0] retired;
`endif

    decode_writeback dut (
        .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .instr_valid(instr_valid), .adr_err(adr_err), .ValE(ValE), .ValM(ValM),
        .ValA(ValA), .ValB(ValB), .stat(stat), .halted(halted)
`ifdef DWB_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  icode, rA, rB;
        logic        cnd, iv, adr;
        logic [63:0] valE, valM;
        logic [63:0] expA, expB;
        logic [1:0]  expS;
    } vec_t;

    typedef struct {
        logic [63:0] a, b;
        logic [1:0]  s;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] ic, input logic [3:0] a,
                                input logic [3:0] b, input logic c, input logic iv,
                                input logic ad, input logic [63:0] e, input logic [63:0] m,
                                input logic [63:0] xa, input logic [63:0] xb,
                                input logic [1:0] xs);
        vec_t v;
        v.rst = r; v.icode = ic; v.rA = a; v.rB = b; v.cnd = c; v.iv = iv; v.adr = ad;
        v.valE = e; v.valM = m; v.expA = xa; v.expB = xb; v.expS = xs;
        return v;
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        icode = v.icode; rA = v.rA; rB = v.rB; cnd = v.cnd;
        instr_valid = v.iv; adr_err = v.adr; ValE = v.valE; ValM = v.valM;
    endtask

    // Called just after a posedge: reads checked before the edge, stat after it.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        if (v.rst) pulse_reset();
        drive(v);
        e.a = v.expA; e.b = v.expB; e.s = v.expS;
        sb.push_back(e);
        #1;
        chk({tag, ".ValA"}, ValA, sb[0].a);
        chk({tag, ".ValB"}, ValB, sb[0].b);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".stat"}, 64'(stat), 64'(e.s));
        chk({tag, ".halted"}, 64'(halted), 64'(e.s != 2'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //           rst ic    rA    rB    c  iv ad ValE      ValM      expA      expB      S
        vt.push_back(mk(0, 4'h4, 4'h0, 4'h4, 0, 1, 0, 0,        0,        0,        8192,     0)); // reset state
        vt.push_back(mk(0, 4'h9, 4'hF, 4'hF, 0, 1, 0, 8192,     0,        8192,     8192,     0)); // ret reads rsp
        vt.push_back(mk(0, 4'h3, 4'hF, 4'h2, 0, 1, 0, 64'h55,   0,        0,        0,        0)); // irmovq r2
        vt.push_back(mk(0, 4'h2, 4'h2, 4'h3, 1, 1, 0, 64'h55,   0,        64'h55,   0,        0)); // cmov taken
        vt.push_back(mk(0, 4'h4, 4'h3, 4'h2, 0, 1, 0, 0,        0,        64'h55,   64'h55,   0)); // probe
        vt.push_back(mk(0, 4'h2, 4'h2, 4'h3, 0, 1, 0, 64'h99,   0,        64'h55,   0,        0)); // cmov not taken
        vt.push_back(mk(0, 4'h4, 4'h3, 4'h0, 0, 1, 0, 0,        0,        64'h55,   0,        0)); // r3 unchanged
        vt.push_back(mk(0, 4'hB, 4'h4, 4'hF, 0, 1, 0, 64'h2008, 64'h1234, 8192,     8192,     0)); // popq %rsp
        vt.push_back(mk(0, 4'h4, 4'h4, 4'hF, 0, 1, 0, 0,        0,        64'h1234, 0,        0)); // M wins
        vt.push_back(mk(0, 4'h5, 4'h1, 4'hF, 0, 1, 0, 0,        64'hDEAD, 0,        0,        0)); // mrmovq r1
        vt.push_back(mk(0, 4'h5, 4'hF, 4'h2, 0, 1, 0, 0,        64'hBEEF, 0,        64'h55,   0)); // dst RNONE
        vt.push_back(mk(0, 4'h4, 4'h1, 4'hF, 0, 1, 0, 0,        0,        64'hDEAD, 0,        0)); // probe r1
        vt.push_back(mk(0, 4'h6, 4'h1, 4'h5, 0, 1, 0, 64'h777,  0,        64'hDEAD, 0,        0)); // OPq r5
        vt.push_back(mk(0, 4'hA, 4'h5, 4'hF, 0, 1, 0, 64'h1000, 0,        64'h777,  64'h1234, 0)); // pushq
        vt.push_back(mk(0, 4'h4, 4'h4, 4'h5, 0, 1, 0, 0,        0,        64'h1000, 64'h777,  0)); // probe
        vt.push_back(mk(0, 4'h5, 4'h1, 4'hF, 0, 1, 1, 0,        7,        0,        0,        2)); // adr fault
        vt.push_back(mk(0, 4'h3, 4'hF, 4'h1, 0, 1, 0, 64'hAA,   0,        0,        0,        2)); // suppressed
        vt.push_back(mk(0, 4'h4, 4'h1, 4'h4, 0, 1, 0, 0,        0,        64'hDEAD, 64'h1000, 2)); // still frozen
        vt.push_back(mk(1, 4'h4, 4'h1, 4'h4, 0, 1, 0, 0,        0,        0,        8192,     0)); // after reset
        vt.push_back(mk(0, 4'h3, 4'hF, 4'h7, 0, 0, 0, 64'h33,   0,        0,        0,        3)); // invalid
        vt.push_back(mk(1, 4'h4, 4'h7, 4'hF, 0, 1, 0, 0,        0,        0,        0,        0)); // no INS write
        vt.push_back(mk(0, 4'h0, 4'hF, 4'hF, 0, 1, 0, 0,        0,        0,        0,        1)); // halt
        vt.push_back(mk(0, 4'h3, 4'hF, 4'h8, 0, 1, 0, 64'h1,    0,        0,        0,        1)); // after halt
        vt.push_back(mk(1, 4'h4, 4'h8, 4'hF, 0, 1, 0, 0,        0,        0,        0,        0)); // r8 untouched

        rst_n = 1'b0;
        drive(mk(0, 4'h1, 4'hF, 4'hF, 0, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("reset.stat", 64'(stat), 64'd0);
        chk("reset.halted", 64'(halted), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) step(vt[i], $sformatf("vec%0d", i));

        // Async reset while halted and mid-instruction: stat clears at once,
        // and the in-flight irmovq to r6 never lands.
        step(mk(0, 4'h0, 4'hF, 4'hF, 0, 1, 0, 0, 0, 0, 0, 1), "pre_rst_halt");
        drive(mk(0, 4'h3, 4'hF, 4'h6, 0, 1, 0, 64'h5, 0, 0, 0, 0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst.stat", 64'(stat), 64'd0);
        chk("async_rst.halted", 64'(halted), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(mk(0, 4'h4, 4'h6, 4'h4, 0, 1, 0, 0, 0, 0, 8192, 0), "async_rst.probe");

`ifdef DWB_RETIRE_CNT_EN
        pulse_reset();
        #1;
        chk("retired.reset", retired, 64'd0);
        for (int k = 0; k < 3; k++)
            step(mk(0, 4'h6, 4'hF, 4'h9, 0, 1, 0, 64'(k), 0, 0, 0, 0), $sformatf("opq%0d", k));
        step(mk(0, 4'h0, 4'hF, 4'hF, 0, 1, 0, 0, 0, 0, 0, 1), "cnt_halt");
        chk("retired.after_halt", retired, 64'd3);
        step(mk(0, 4'h6, 4'hF, 4'h9, 0, 1, 0, 64'h9, 0, 0, 0, 1), "cnt_frozen");
        chk("retired.frozen", retired, 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Register file plus decode/write-back logic for the SEQ datapath.
- Decode: combinationally supplies ValA/ValB to execute and memory from fifteen 64-bit program registers, selected by icode/rA/rB.
- Write-back: on the clock edge, consumes ValE from execute and ValM from memory and retires register writes.
- Holds the sticky processor status (AOK/HLT/ADR/INS) and freezes architectural state once a fault or halt retires.

Parameters:
- DATA_W, 64, register and data width.
- RSP_INIT, 64'd8192, reset value of %rsp (reg 4); all other registers reset to 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- icode  in  4  current instruction code
- rA  in  4  register specifier A; 4'hF = RNONE
- rB  in  4  register specifier B; 4'hF = RNONE
- cnd  in  1  condition result from execute (cmovXX gating)
- instr_valid  in  1  fetch decoded a legal instruction
- adr_err  in  1  memory-stage address fault for the current instruction
- ValE  in  DATA_W  execute result
- ValM  in  DATA_W  memory read data
- ValA  out  DATA_W  register read port A (combinational)
- ValB  out  DATA_W  register read port B (combinational)
- stat  out  2  status register: 0=AOK, 1=HLT, 2=ADR, 3=INS
- halted  out  1  high whenever stat != AOK

Behaviour:
- Reset (rst_n low, asynchronous): regs[0..14]=0 except regs[4]=RSP_INIT; stat=AOK; halted=0. Reset mid-instruction drops that instruction's writes.
- srcA:
  - rA for icode 2, 4, 6, A.
  - 4 (%rsp) for icode 9, B.
  - otherwise RNONE.
- srcB:
  - rB for icode 4, 5, 6.
  - 4 for icode 8, 9, A, B.
  - otherwise RNONE.
- Reads: ValA=regs[srcA], ValB=regs[srcB]; RNONE reads 0. Reads are combinational, 0-cycle latency, and return pre-edge contents (no write forwarding).
- dstE:
  - rB for icode 2 when cnd=1; RNONE when cnd=0.
  - rB for icode 3, 6.
  - 4 for icode 8, 9, A, B.
  - otherwise RNONE.
- dstM: rA for icode 5, B; otherwise RNONE.
- Write-back on posedge clk, only when stat==AOK and the retiring instruction is not faulting:
  - regs[dstE] <= ValE; regs[dstM] <= ValM. Both ports may write in one cycle.
  - dstE==dstM (popq %rsp): ValM wins; final %rsp = ValM.
  - Writes to RNONE are discarded.
- Status update, posedge, priority order:
  - if stat!=AOK: hold (sticky until reset).
  - else if !instr_valid: stat<=INS.
  - else if adr_err: stat<=ADR.
  - else if icode==0: stat<=HLT.
  - else: stays AOK.
- A faulting or halting instruction performs no register writes in its own cycle.
- Once stat!=AOK, all register writes are suppressed; ValA/ValB remain readable for debug.
- Widths: no arithmetic in this block; values are stored unmodified at DATA_W.

Optional Feature:
- Macro: DWB_RETIRE_CNT_EN.
- Defined:
  - Adds output port retired (64 bits), reset to 0.
  - Increments by 1 at each posedge where stat==AOK, instr_valid=1, adr_err=0 and icode!=0; wraps modulo 2^64.
  - Halt, faults and suppressed cycles do not count.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 then 1 -> stat=0, halted=0, regs[4]=8192, regs[0]=0; icode=9 -> ValA=ValB=8192.
- irmovq: icode=3, rB=2, ValE=0x55 -> next cycle icode=2, rA=2, cnd=1, rB=3, ValE=0x55 -> regs[3]=0x55. Repeat with cnd=0 -> regs[3] unchanged.
- popq %rsp: icode=B, rA=4, ValE=0x2008, ValM=0x1234 -> regs[4]=0x1234.
- mrmovq: icode=5, rA=1, ValM=0xDEAD -> regs[1]=0xDEAD. Same cycle: rB=F gives ValB=0; rA=F writes nothing.
- Address fault: icode=5, rA=1, adr_err=1, ValM=7 -> regs[1] unchanged, stat=2, halted=1. Further legal icode=3 writes are ignored; stat stays 2 until rst_n low.
- Invalid and halt: instr_valid=0 -> stat=3. After reset, icode=0 -> stat=1. With DWB_RETIRE_CNT_EN, three OPq then halt -> retired=3.
